// File: rtl/reaction_ctrl.sv
// Reaction-time game controller: random foreperiod, stimulus lamp, external
// ms timer start/stop, result capture and best-time tracking.
module reaction_ctrl #(
  parameter int CLKSPDMHZ     = 100,
  parameter int MIN_DELAY_MS  = 1000,
  parameter int DELAY_SPAN_MS = 2048,
  parameter int TIMEOUT_MS    = 9999
) (
  input  logic        clk,
  input  logic        res,
  input  logic        btn,
  input  logic [15:0] ms_elapsed,
  output logic        tmr_start,
  output logic        tmr_stop,
  output logic        tmr_res,
  output logic        led,
  output logic [15:0] result_ms,
  output logic [15:0] best_ms,
  output logic        false_start,
  output logic        timeout,
  output logic [2:0]  fsm_state
);

  localparam int TICK_CYC = CLKSPDMHZ * 1000;
  localparam int PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_CYC - 1);
  localparam logic [15:0]   SPAN_MASK = 16'(DELAY_SPAN_MS - 1);
  localparam logic [15:0]   MIN_DLY   = 16'(MIN_DELAY_MS);
  localparam logic [15:0]   TO_VAL    = 16'(TIMEOUT_MS);

  // Encoding is visible on fsm_state: IDLE=0 DELAY=1 ARMED=2 CAPTURE=3 DONE=4 FOUL=5.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DELAY   = 3'd1,
    ARMED   = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4,
    FOUL    = 3'd5
  } state_t;

  state_t        state, state_n;
  logic          btn_q;
  logic          btn_rise;
  logic [15:0]   lfsr;
  logic [PW-1:0] prescaler, prescaler_n;
  logic [15:0]   delay_ms, delay_n;
  logic          cap_cnt, cap_n;
  logic          led_n, start_n, stop_n, tres_n;
  logic [15:0]   result_n, best_n;
  logic          fs_n, to_n;

  assign btn_rise  = btn & ~btn_q;
  assign fsm_state = state;

  always_comb begin
    state_n     = state;
    prescaler_n = prescaler;
    delay_n     = delay_ms;
    cap_n       = cap_cnt;
    start_n     = 1'b0;
    stop_n      = 1'b0;
    tres_n      = 1'b0;
    result_n    = result_ms;
    best_n      = best_ms;
    fs_n        = false_start;
    to_n        = timeout;
    case (state)
      IDLE, DONE: begin
        if (btn_rise) begin
          delay_n     = MIN_DLY + (lfsr & SPAN_MASK);
          prescaler_n = '0;
          fs_n        = 1'b0;
          to_n        = 1'b0;
          tres_n      = 1'b1;
          state_n     = DELAY;
        end
      end
      DELAY: begin
        // A press always beats a coincident expiry.
        if (btn_rise) begin
          fs_n    = 1'b1;
          state_n = FOUL;
        end else if (prescaler == PRE_MAX) begin
          prescaler_n = '0;
          if (delay_ms <= 16'd1) begin
            delay_n = '0;
            start_n = 1'b1;
            state_n = ARMED;
          end else begin
            delay_n = delay_ms - 16'd1;
          end
        end else begin
          prescaler_n = prescaler + PW'(1);
        end
      end
      ARMED: begin
        if (btn_rise) begin
          stop_n  = 1'b1;
          cap_n   = 1'b0;
          state_n = CAPTURE;
        end else if (ms_elapsed == TO_VAL) begin
          stop_n  = 1'b1;
          to_n    = 1'b1;
          cap_n   = 1'b0;
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        // Second cycle: the timer's registered count has settled after the stop.
        if (cap_cnt) begin
          result_n = timeout ? TO_VAL : ms_elapsed;
          if (!timeout && (ms_elapsed < best_ms)) best_n = ms_elapsed;
          state_n  = DONE;
        end else begin
          cap_n = 1'b1;
        end
      end
      FOUL: begin
        if (btn_rise) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    led_n = (state_n == ARMED);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state       <= IDLE;
      btn_q       <= 1'b0;
      lfsr        <= 16'hACE1;
      prescaler   <= '0;
      delay_ms    <= '0;
      cap_cnt     <= 1'b0;
      led         <= 1'b0;
      tmr_start   <= 1'b0;
      tmr_stop    <= 1'b0;
      tmr_res     <= 1'b1;
      result_ms   <= '0;
      best_ms     <= 16'hFFFF;
      false_start <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      btn_q       <= btn;
      lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      prescaler   <= prescaler_n;
      delay_ms    <= delay_n;
      cap_cnt     <= cap_n;
      led         <= led_n;
      tmr_start   <= start_n;
      tmr_stop    <= stop_n;
      tmr_res     <= tres_n;
      result_ms   <= result_n;
      best_ms     <= best_n;
      false_start <= fs_n;
      timeout     <= to_n;
    end
  end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl: attached ms timer model, LFSR-based foreperiod
// prediction, directed scenario rounds plus randomized reaction times.
module tb_reaction_ctrl;

  localparam int CLKMHZ   = 1;
  localparam int MIN_D    = 2;
  localparam int SPAN     = 4;
  localparam int TO       = 50;
  localparam int TICK_CYC = CLKMHZ * 1000;
  localparam int TMR_DIV  = 20;  // timer counts a "ms" every TMR_DIV clocks to keep runs short
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_FOUL = 3'd5;

  logic        clk = 1'b0;
  logic        res;
  logic        btn;
  logic [15:0] ms_elapsed;
  logic        tmr_start, tmr_stop, tmr_res, led;
  logic [15:0] result_ms, best_ms;
  logic        false_start, timeout;
  logic [2:0]  fsm_state;

  reaction_ctrl #(
    .CLKSPDMHZ(CLKMHZ), .MIN_DELAY_MS(MIN_D), .DELAY_SPAN_MS(SPAN), .TIMEOUT_MS(TO)
  ) dut (
    .clk(clk), .res(res), .btn(btn), .ms_elapsed(ms_elapsed),
    .tmr_start(tmr_start), .tmr_stop(tmr_stop), .tmr_res(tmr_res), .led(led),
    .result_ms(result_ms), .best_ms(best_ms),
    .false_start(false_start), .timeout(timeout), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- timer model ----------------
  logic [15:0] tm_cnt = '0;
  int          tm_pre = 0;
  logic        tm_run = 1'b0;
  assign ms_elapsed = tm_cnt;

  always @(posedge clk) begin
    if (tmr_res) begin
      tm_cnt <= '0; tm_pre <= 0; tm_run <= 1'b0;
    end else if (tmr_start) begin
      tm_cnt <= '0; tm_pre <= 0; tm_run <= 1'b1;
    end else if (tmr_stop) begin
      tm_run <= 1'b0;
    end else if (tm_run) begin
      if (tm_pre == TMR_DIV - 1) begin
        tm_pre <= 0;
        tm_cnt <= tm_cnt + 16'd1;
      end else begin
        tm_pre <= tm_pre + 1;
      end
    end
  end

  // ---------------- reference model state ----------------
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk or posedge res) begin
    if (res) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_next(m_lfsr);
  end

  int m_best = 65535;
  logic [15:0] exp_q[$];

  // Pulse / lamp monitors, sampled away from the active edge.
  int n_start = 0, n_stop = 0, n_tres = 0, n_overlap = 0, n_led = 0;
  always @(negedge clk) begin
    if (!res) begin
      n_start += int'(tmr_start);
      n_stop  += int'(tmr_stop);
      n_tres  += int'(tmr_res);
      n_led   += int'(led);
      if (int'(tmr_start) + int'(tmr_stop) + int'(tmr_res) > 1) n_overlap++;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  int start0, stop0, tres0, led0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic press();
    btn = 1'b1;
    tick();
    btn = 1'b0;
  endtask

  task automatic start_round(output int d);
    d = MIN_D + int'(m_lfsr & 16'(SPAN - 1));
    start0 = n_start; stop0 = n_stop; tres0 = n_tres; led0 = n_led;
    press();
    check("round_start_tmr_res", n_tres - tres0, 1);
    check("round_start_flags", {false_start, timeout}, 0);
  endtask

  task automatic wait_led(input int d);
    int cnt;
    cnt = 1;
    while (!led && cnt < 10000) begin
      tick();
      cnt++;
    end
    check("led_latency_cycles", cnt, d * TICK_CYC + 1);
    check("tmr_start_pulses", n_start - start0, 1);
  endtask

  task automatic wait_ms(input int v);
    int guard;
    guard = 0;
    while (ms_elapsed != 16'(v) && guard < 5000) begin
      tick();
      guard++;
    end
    check("ms_elapsed_reached", ms_elapsed, v);
  endtask

  task automatic finish_round(input logic exp_to);
    logic [15:0] exp_r;
    exp_r = exp_q.pop_front();
    check("result_ms", result_ms, exp_r);
    check("best_ms", best_ms, m_best);
    check("timeout_flag", timeout, exp_to);
    check("false_start_flag", false_start, 0);
    check("tmr_stop_pulses", n_stop - stop0, 1);
    check("state_done", fsm_state, ST_DONE);
    check("led_off_after", led, 0);
  endtask

  task automatic play_round(input int ms);
    int d;
    start_round(d);
    wait_led(d);
    wait_ms(ms);
    press();
    if (ms < m_best) m_best = ms;
    exp_q.push_back(16'(ms));
    repeat (3) tick();
    finish_round(1'b0);
  endtask

  task automatic timeout_round();
    int d;
    start_round(d);
    wait_led(d);
    wait_ms(TO);
    exp_q.push_back(16'(TO));
    repeat (3) tick();
    finish_round(1'b1);
  endtask

  task automatic press_at_timeout_round();
    int d;
    start_round(d);
    wait_led(d);
    wait_ms(TO);
    press();
    if (TO < m_best) m_best = TO;
    exp_q.push_back(16'(TO));
    repeat (3) tick();
    finish_round(1'b0);
  endtask

  task automatic false_start_round(input int press_after);
    int d;
    start_round(d);
    repeat (press_after) tick();
    press();
    tick();
    check("foul_state", fsm_state, ST_FOUL);
    check("foul_flag", false_start, 1);
    check("foul_led", led, 0);
    repeat (5 * TICK_CYC) tick();
    check("foul_no_tmr_start", n_start - start0, 0);
    check("foul_led_never", n_led - led0, 0);
    press();
    tick();
    check("foul_to_idle", fsm_state, ST_IDLE);
    check("foul_flag_held", false_start, 1);
    check("foul_no_extra_res", n_tres - tres0, 1);
  endtask

  task automatic false_start_on_expiry();
    int d;
    start_round(d);
    repeat (d * TICK_CYC - 1) tick();
    press();
    tick();
    check("expiry_foul_state", fsm_state, ST_FOUL);
    check("expiry_foul_flag", false_start, 1);
    check("expiry_no_start", n_start - start0, 0);
    check("expiry_led", n_led - led0, 0);
    press();
    tick();
    check("expiry_to_idle", fsm_state, ST_IDLE);
  endtask

  task automatic reset_mid_armed();
    int d;
    start_round(d);
    wait_led(d);
    repeat (40) tick();
    stop0 = n_stop;
    res = 1'b1;
    #1;
    check("rst_led", led, 0);
    check("rst_state", fsm_state, ST_IDLE);
    check("rst_best", best_ms, 16'hFFFF);
    check("rst_result", result_ms, 0);
    check("rst_tmr_res", tmr_res, 1);
    check("rst_tmr_stop", tmr_stop, 0);
    repeat (3) tick();
    check("rst_tmr_res_held", tmr_res, 1);
    res = 1'b0;
    m_best = 65535;
    exp_q.delete();
    repeat (5) tick();
    check("rst_no_stop_pulse", n_stop - stop0, 0);
    check("rst_idle_after", fsm_state, ST_IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    btn = 1'b0;
    res = 1'b1;
    repeat (3) tick();
    check("reset_state", fsm_state, ST_IDLE);
    check("reset_led", led, 0);
    check("reset_tmr_start", tmr_start, 0);
    check("reset_tmr_stop", tmr_stop, 0);
    check("reset_tmr_res", tmr_res, 1);
    check("reset_result", result_ms, 0);
    check("reset_best", best_ms, 16'hFFFF);
    check("reset_false_start", false_start, 0);
    check("reset_timeout", timeout, 0);
    res = 1'b0;
    tick();
    check("tmr_res_released", tmr_res, 0);

    play_round(7);
    play_round(9);
    play_round(5);
    play_round(12);
    false_start_round(TICK_CYC - 1);
    timeout_round();
    false_start_on_expiry();
    repeat (3) play_round(int'($urandom_range(1, 40)));
    reset_mid_armed();
    press_at_timeout_round();

    check("pulse_overlap", n_overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop if something wedges the sequence.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
